// File: rtl/fft_pkg.sv
// Shared types and elaboration-time helpers for the radix-2 FFT sequencer.
// Twiddle quantisation is symmetric round-to-nearest on a +/-(2**(W-1)-1) scale.
package fft_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} fft_state_t;

   localparam real TWO_PI = 6.283185307179586;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   function automatic real tw_scale(input int data_width);
      return real'((1 << (data_width - 1)) - 1);
   endfunction

   // Rounds half away from zero so +x and -x quantise to mirrored codes.
   function automatic int tw_quant(input real x, input int data_width);
      real v;
      v = x * tw_scale(data_width);
      if (v >= 0.0) return $rtoi(v + 0.5);
      return -$rtoi(0.5 - v);
   endfunction

endpackage

// File: rtl/fft_seq_controller_if.sv
// Sequencer-side bundle: start/mode in, RAM addressing, write-back and twiddles out.
interface fft_seq_controller_if
   import fft_pkg::*;
#(
   parameter int LOG2_N     = 4,
   parameter int DATA_WIDTH = 18
);
   localparam int STAGE_W = clog2(LOG2_N) + 1;

   logic                         start;
   logic                         inverse;
   logic                         busy;
   logic                         done;
   logic                         q_sel;
   logic                         we_sel;
   logic [LOG2_N-1:0]            rd_addr_a;
   logic [LOG2_N-1:0]            rd_addr_b;
   logic                         we_a;
   logic                         we_b;
   logic [LOG2_N-1:0]            wr_addr_a;
   logic [LOG2_N-1:0]            wr_addr_b;
   logic signed [DATA_WIDTH-1:0] twiddle_r;
   logic signed [DATA_WIDTH-1:0] twiddle_i;
   logic [STAGE_W-1:0]           stage;
   logic                         result_bank;

   modport master (
      input  start, inverse,
      output busy, done, q_sel, we_sel, rd_addr_a, rd_addr_b, we_a, we_b,
             wr_addr_a, wr_addr_b, twiddle_r, twiddle_i, stage, result_bank
   );

   modport slave (
      output start, inverse,
      input  busy, done, q_sel, we_sel, rd_addr_a, rd_addr_b, we_a, we_b,
             wr_addr_a, wr_addr_b, twiddle_r, twiddle_i, stage, result_bank
   );

endinterface

// File: rtl/fft_twiddle_rom.sv
// N/2-entry twiddle table built at elaboration; one-cycle registered output.
// conj flips the imaginary part for the inverse transform.
module fft_twiddle_rom
   import fft_pkg::*;
#(
   parameter int LOG2_N     = 4,
   parameter int DATA_WIDTH = 18
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         conj,
   input  logic [LOG2_N-2:0]            k,
   output logic signed [DATA_WIDTH-1:0] twiddle_r,
   output logic signed [DATA_WIDTH-1:0] twiddle_i
);
   localparam int N = 1 << LOG2_N;

   logic signed [DATA_WIDTH-1:0] rom_r [N/2];
   logic signed [DATA_WIDTH-1:0] rom_i [N/2];

   for (genvar g = 0; g < N/2; g++) begin : g_rom
      localparam real ANGLE = TWO_PI * real'(g) / real'(N);
      localparam int  RE    = tw_quant($cos(ANGLE), DATA_WIDTH);
      localparam int  IM    = tw_quant($sin(ANGLE), DATA_WIDTH);
      assign rom_r[g] = DATA_WIDTH'(RE);
      assign rom_i[g] = DATA_WIDTH'(-IM);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         twiddle_r <= '0;
         twiddle_i <= '0;
      end else if (en) begin
         twiddle_r <= rom_r[k];
         twiddle_i <= conj ? -rom_i[k] : rom_i[k];
      end
   end

endmodule

// File: rtl/fft_seq_controller.sv
// Radix-2 DIT FFT sequencer: one butterfly per cycle over a ping-pong RAM pair.
//   state | meaning
//   IDLE  | waiting for start
//   ISSUE | issuing butterfly j of the current stage
//   DRAIN | 1+BFLY_LAT cycles letting write-back land before the next stage reads
//   FIN   | one-cycle done pulse
module fft_seq_controller
   import fft_pkg::*;
#(
   parameter int LOG2_N     = 4,
   parameter int DATA_WIDTH = 18,
   parameter int BFLY_LAT   = 2
)(
   input  logic                clk,
   input  logic                rst,
   fft_seq_controller_if.master bus
);
   localparam int N       = 1 << LOG2_N;
   localparam int HALF    = N / 2;
   localparam int KW      = LOG2_N - 1;
   localparam int DLY     = 1 + BFLY_LAT;
   localparam int STAGE_W = clog2(LOG2_N) + 1;
   localparam int CNT_W   = clog2(DLY + 1);

   typedef struct packed {
      logic              valid;
      logic [LOG2_N-1:0] a;
      logic [LOG2_N-1:0] b;
   } wb_t;

   fft_state_t         state, state_nxt;
   logic [KW-1:0]      j;
   logic [STAGE_W-1:0] s;
   logic [CNT_W-1:0]   drain_cnt;
   logic               inv_q;
   logic               issue, busy, last_bfly, last_stage, drain_tc;
   logic [LOG2_N-1:0]  j_ext, span, low, addr_a, addr_b, rd_a, rd_b;
   logic [KW-1:0]      k;
   wb_t                dly_q [DLY];

   assign issue      = (state == ISSUE);
   assign busy       = issue || (state == DRAIN);
   assign last_bfly  = (j == KW'(HALF - 1));
   assign last_stage = (s == STAGE_W'(LOG2_N - 1));
   assign drain_tc   = (drain_cnt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = ISSUE;
         ISSUE:   if (last_bfly) state_nxt = DRAIN;
         DRAIN:   if (drain_tc)  state_nxt = last_stage ? FIN : ISSUE;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         j         <= '0;
         s         <= '0;
         drain_cnt <= '0;
         inv_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               j     <= '0;
               s     <= '0;
               inv_q <= bus.inverse;
            end
            ISSUE: begin
               j         <= j + 1'b1;
               drain_cnt <= CNT_W'(DLY - 1);
            end
            DRAIN: begin
               if (!drain_tc) drain_cnt <= drain_cnt - 1'b1;
               else           s <= last_stage ? '0 : s + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Pair (a, a+span) with bit s of a clear; j's low s bits stay in place.
   always_comb begin
      j_ext  = {1'b0, j};
      span   = LOG2_N'(1) << s;
      low    = j_ext & (span - 1'b1);
      addr_a = ((j_ext >> s) << (s + 1'b1)) | low;
      addr_b = addr_a | span;
      k      = KW'(low << (KW - int'(s)));
      rd_a   = issue ? addr_a : '0;
      rd_b   = issue ? addr_b : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DLY; i++) dly_q[i] <= '0;
      end else begin
         dly_q[0] <= {issue, rd_a, rd_b};
         for (int i = 1; i < DLY; i++) dly_q[i] <= dly_q[i-1];
      end
   end

   fft_twiddle_rom #(
      .LOG2_N     (LOG2_N),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_twiddle_rom (
      .clk       (clk),
      .rst       (rst),
      .en        (issue),
      .conj      (inv_q),
      .k         (k),
      .twiddle_r (bus.twiddle_r),
      .twiddle_i (bus.twiddle_i)
   );

   assign bus.busy        = busy;
   assign bus.done        = (state == FIN);
   assign bus.q_sel       = busy & s[0];
   assign bus.we_sel      = busy & ~s[0];
   assign bus.rd_addr_a   = rd_a;
   assign bus.rd_addr_b   = rd_b;
   assign bus.we_a        = dly_q[DLY-1].valid;
   assign bus.we_b        = dly_q[DLY-1].valid;
   assign bus.wr_addr_a   = dly_q[DLY-1].a;
   assign bus.wr_addr_b   = dly_q[DLY-1].b;
   assign bus.stage       = s;
   assign bus.result_bank = 1'(LOG2_N % 2);

endmodule

// File: tb/tb_fft_seq_controller.sv
// Randomised bench for fft_seq_controller against a cycle-indexed arithmetic model
// of the issue schedule, write-back timing and quantised twiddles.
module tb_fft_seq_controller;

   localparam int LOG2_N     = 4;
   localparam int DATA_WIDTH = 18;
   localparam int BFLY_LAT   = 2;
   localparam int N          = 1 << LOG2_N;
   localparam int HALF       = N / 2;
   localparam int P          = HALF + 1 + BFLY_LAT;
   localparam int RUN        = LOG2_N * P;
   localparam int FULL       = (1 << (DATA_WIDTH - 1)) - 1;
   localparam real PI2       = 6.283185307179586;

   typedef struct {
      bit issue;
      int s;
      int a;
      int b;
      int k;
   } rd_t;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   fft_seq_controller_if #(.LOG2_N(LOG2_N), .DATA_WIDTH(DATA_WIDTH)) bus ();

   fft_seq_controller #(
      .LOG2_N     (LOG2_N),
      .DATA_WIDTH (DATA_WIDTH),
      .BFLY_LAT   (BFLY_LAT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   function automatic int qround(input real x);
      if (x >= 0.0) return int'($floor(x + 0.5));
      return -int'($floor(0.5 - x));
   endfunction

   // Cycle c counts from 1 = first cycle after the edge that accepted start.
   function automatic rd_t ref_read(input int c);
      rd_t r;
      int  off, span, jj;
      r = '{0, 0, 0, 0, 0};
      if (c < 1 || c > RUN) return r;
      r.s = (c - 1) / P;
      off = (c - 1) % P;
      if (off >= HALF) return r;
      span    = 1 << r.s;
      jj      = off;
      r.issue = 1'b1;
      r.a     = (jj / span) * 2 * span + jj % span;
      r.b     = r.a + span;
      r.k     = (jj % span) * (N / (2 * span));
      return r;
   endfunction

   function automatic int ref_tw_r(input int kk);
      return qround(real'(FULL) * $cos(PI2 * real'(kk) / real'(N)));
   endfunction

   function automatic int ref_tw_i(input int kk, input bit inv);
      int v;
      v = qround(real'(FULL) * $sin(PI2 * real'(kk) / real'(N)));
      return inv ? v : -v;
   endfunction

   task automatic check_reset(input string tag);
      check({tag, "_busy"},   bus.busy, 0);
      check({tag, "_done"},   bus.done, 0);
      check({tag, "_q_sel"},  bus.q_sel, 0);
      check({tag, "_we_sel"}, bus.we_sel, 0);
      check({tag, "_rd_a"},   bus.rd_addr_a, 0);
      check({tag, "_rd_b"},   bus.rd_addr_b, 0);
      check({tag, "_we_a"},   bus.we_a, 0);
      check({tag, "_we_b"},   bus.we_b, 0);
      check({tag, "_wr_a"},   bus.wr_addr_a, 0);
      check({tag, "_wr_b"},   bus.wr_addr_b, 0);
      check({tag, "_tw_r"},   bus.twiddle_r, 0);
      check({tag, "_tw_i"},   bus.twiddle_i, 0);
      check({tag, "_stage"},  bus.stage, 0);
      check({tag, "_rbank"},  bus.result_bank, LOG2_N % 2);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         check("idle_busy", bus.busy, 0);
         check("idle_done", bus.done, 0);
      end
   endtask

   // Start one transform and check every cycle through the done cycle.
   // ign_cyc: cycle in which a stray start is driven; rst_cyc: abort point;
   // chain: hold start through the done cycle and the following idle cycle.
   task automatic run_xform(input bit inv, input int ign_cyc, input int rst_cyc, input bit chain);
      int wcnt [LOG2_N][N];
      int writes;
      writes = 0;
      for (int si = 0; si < LOG2_N; si++)
         for (int ai = 0; ai < N; ai++) wcnt[si][ai] = 0;
      bus.start   = 1'b1;
      bus.inverse = inv;
      for (int c = 1; c <= RUN + 1; c++) begin
         rd_t rd, prv, wb;
         @(posedge clk);
         #1;
         bus.start   = (c == ign_cyc) || (chain && c == RUN + 1);
         bus.inverse = 1'($urandom);
         @(negedge clk);
         if (c == rst_cyc) begin
            rst = 1'b1;
            #1;
            check_reset("abort");
            bus.start = 1'b0;
            repeat (3) begin
               @(negedge clk);
               check("abort_done", bus.done, 0);
            end
            rst = 1'b0;
            return;
         end
         rd  = ref_read(c);
         prv = ref_read(c - 1);
         wb  = ref_read(c - 1 - BFLY_LAT);
         check("busy", bus.busy, (c <= RUN) ? 1 : 0);
         check("done", bus.done, (c == RUN + 1) ? 1 : 0);
         check("rd_addr_a", bus.rd_addr_a, rd.a);
         check("rd_addr_b", bus.rd_addr_b, rd.b);
         check("q_sel", bus.q_sel, (c <= RUN) ? rd.s % 2 : 0);
         check("we_sel", bus.we_sel, (c <= RUN) ? 1 - rd.s % 2 : 0);
         if (c <= RUN) check("stage", bus.stage, rd.s);
         check("we_a", bus.we_a, int'(wb.issue));
         check("we_b", bus.we_b, int'(wb.issue));
         if (wb.issue) begin
            check("wr_addr_a", bus.wr_addr_a, wb.a);
            check("wr_addr_b", bus.wr_addr_b, wb.b);
         end
         if (prv.issue) begin
            check("twiddle_r", bus.twiddle_r, ref_tw_r(prv.k));
            check("twiddle_i", bus.twiddle_i, ref_tw_i(prv.k, inv));
         end
         if (c == 2) begin
            check("t2_tw_r", bus.twiddle_r, 131071);
            check("t2_tw_i", bus.twiddle_i, 0);
         end
         if (c == 13) check("t3_rd_b", bus.rd_addr_b, 3);
         if (c == 14) check("t3_tw_i", bus.twiddle_i, inv ? 131071 : -131071);
         if (bus.we_a) begin
            writes++;
            if (c <= RUN) begin
               wcnt[(c - 1) / P][bus.wr_addr_a]++;
               wcnt[(c - 1) / P][bus.wr_addr_b]++;
            end
         end
      end
      check("write_cycles", writes, HALF * LOG2_N);
      for (int si = 0; si < LOG2_N; si++)
         for (int ai = 0; ai < N; ai++) check("addr_once", wcnt[si][ai], 1);
      if (chain) begin
         @(posedge clk);
         @(negedge clk);
         check("after_done_busy", bus.busy, 0);
      end else begin
         bus.start = 1'b0;
      end
   endtask

   initial begin
      rst         = 1'b1;
      bus.start   = 1'b0;
      bus.inverse = 1'b0;
      repeat (20) @(negedge clk);
      check_reset("reset");
      rst = 1'b0;
      idle(10);

      run_xform(1'b0, 0, 0, 1'b0);
      idle(3);
      run_xform(1'b1, 0, 0, 1'b0);
      idle(2);
      run_xform(1'b1, 10, 0, 1'b1);
      run_xform(1'($urandom), 0, 0, 1'b0);
      idle(2);
      run_xform(1'b0, 0, 20, 1'b0);
      idle(3);
      run_xform(1'b0, 0, 0, 1'b0);
      repeat (4) begin
         idle($urandom_range(1, 5));
         run_xform(1'($urandom), $urandom_range(1, RUN), 0, 1'b0);
      end
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
